shift_seq_ctrl: RTL and testbench

//  Sequencer for the shift datapath pair: one 6-bit up/down counter and one 32-bit shift register,

---
 rtl/shift_seq_ctrl_pkg.sv | 21 ++
 rtl/shift_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift sequencer: datapath mode codes, FSM state encoding
// and a helper that maps the captured direction onto a shifter mode.
package shift_seq_ctrl_pkg;

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_UP_SHL = 2'b01;
    localparam logic [1:0] M_DN_SHR = 2'b10;
    localparam logic [1:0] M_LOAD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? M_DN_SHR : M_UP_SHL;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a counter/shifter pair: loads both, then shifts and counts down until the
// counter reaches zero, with a watchdog that ends the operation with err if it never does.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int CNT_W     = 6,
    parameter int MAX_SHIFT = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amt,
    input  logic             abort,
    input  logic             done_ack,
    input  logic [CNT_W-1:0] cnt_q,
    output logic [1:0]       cnt_m,
    output logic [CNT_W-1:0] cnt_d,
    output logic [1:0]       sh_m,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_AMT    = CNT_W'(MAX_SHIFT);
    localparam logic [CNT_W:0]   WDOG_LIMIT = (CNT_W+1)'(MAX_SHIFT + 1);

    state_t           state_reg, state_next;
    logic             dir_reg,   dir_next;
    logic [CNT_W-1:0] amt_reg,   amt_next;
    logic [CNT_W:0]   wdog_reg,  wdog_next;
    logic             err_reg,   err_next;

    logic [CNT_W:0]   wdog_inc;
    logic             wdog_trip;
    logic             cnt_zero;

    assign wdog_inc  = wdog_reg + 1'b1;
    assign wdog_trip = (wdog_inc == WDOG_LIMIT);
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        amt_next   = amt_reg;
        wdog_next  = wdog_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    dir_next   = dir;
                    amt_next   = (amt > MAX_AMT) ? MAX_AMT : amt;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                wdog_next  = '0;
                state_next = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                // abort outranks both normal completion and the watchdog
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_zero) begin
                    state_next = S_DONE;
                end else if (wdog_trip) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    wdog_next  = wdog_inc;
                end
            end
            S_DONE: begin
                if (done_ack) begin
                    err_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= S_IDLE;
            dir_reg   <= 1'b0;
            amt_reg   <= '0;
            wdog_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            amt_reg   <= amt_next;
            wdog_reg  <= wdog_next;
            err_reg   <= err_next;
        end
    end

    // In SHIFT the modes also look at the counter feedback so that the cycle in which the
    // counter already reads zero performs no extra step; no upstream request reaches an output.
    always_comb begin
        cnt_m = M_HOLD;
        sh_m  = M_HOLD;
        cnt_d = '0;
        busy  = (state_reg != S_IDLE);
        done  = (state_reg == S_DONE);
        err   = err_reg;
        case (state_reg)
            S_LOAD: begin
                cnt_m = M_LOAD;
                sh_m  = M_LOAD;
                cnt_d = amt_reg;
            end
            S_SHIFT: begin
                if (!cnt_zero && !wdog_trip) begin
                    cnt_m = M_DN_SHR;
                    sh_m  = shift_mode(dir_reg);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: closes the loop through simple counter and shifter models and checks
// results against shift amounts, latencies and step counts computed directly from the operation rules.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    localparam int CNT_W     = 6;
    localparam int MAX_SHIFT = 32;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amt;
    logic             abort;
    logic             done_ack;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cnt_m;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       sh_m;
    logic             busy;
    logic             done;
    logic             err;

    logic [CNT_W-1:0] cnt_val;
    logic [31:0]      sh_val;
    logic [31:0]      sh_din;
    logic             stuck;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl #(.CNT_W(CNT_W), .MAX_SHIFT(MAX_SHIFT)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dir      (dir),
        .amt      (amt),
        .abort    (abort),
        .done_ack (done_ack),
        .cnt_q    (cnt_q),
        .cnt_m    (cnt_m),
        .cnt_d    (cnt_d),
        .sh_m     (sh_m),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // up/down counter and shift register driven by the sequencer
    always_ff @(posedge clk) begin
        if (clr) cnt_val <= '0;
        else case (cnt_m)
            M_UP_SHL: cnt_val <= cnt_val + 1'b1;
            M_DN_SHR: cnt_val <= cnt_val - 1'b1;
            M_LOAD:   cnt_val <= cnt_d;
            default:  cnt_val <= cnt_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) sh_val <= '0;
        else case (sh_m)
            M_UP_SHL: sh_val <= sh_val << 1;
            M_DN_SHR: sh_val <= sh_val >> 1;
            M_LOAD:   sh_val <= sh_din;
            default:  sh_val <= sh_val;
        endcase
    end

    assign cnt_q = stuck ? 6'd5 : cnt_val;

    function automatic int clamp_amt(input logic [CNT_W-1:0] a);
        return (int'(a) > MAX_SHIFT) ? MAX_SHIFT : int'(a);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] data, input logic d, input int s);
        logic [31:0] r;
        r = data;
        for (int k = 0; k < s; k++) r = d ? (r >> 1) : (r << 1);
        return r;
    endfunction

    // Issue one operation; returns cycles from the start edge to DONE and the number of decrement cycles.
    task automatic do_op(input logic [31:0] data, input logic d, input logic [CNT_W-1:0] a,
                         output int lat, output int decs);
        @(negedge clk);
        sh_din = data; dir = d; amt = a; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dir = ~d; amt = ~a;
        lat = 0; decs = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (cnt_m === M_DN_SHR) decs++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic ack_done();
        @(negedge clk);
        done_ack = 1'b1;
        @(posedge clk);
        #1;
        done_ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; dir = 1'b0; amt = '0; abort = 1'b0; done_ack = 1'b0;
        sh_din = '0; stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (cnt_m !== 2'b00) begin n_bad++; $display("FAIL reset_cnt_m: got %b expected 00", cnt_m); end
        n_cmp++; if (sh_m !== 2'b00)  begin n_bad++; $display("FAIL reset_sh_m: got %b expected 00", sh_m); end
        n_cmp++; if (cnt_d !== '0)    begin n_bad++; $display("FAIL reset_cnt_d: got %0d expected 0", cnt_d); end
        $display("reset: busy=%b done=%b err=%b", busy, done, err);
    endtask

    task automatic test_shift_ops();
        logic [31:0]      t_data [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic             t_dir  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [CNT_W-1:0] t_amt  [4] = '{6'd4, 6'd31, 6'd40, 6'd0};
        for (int i = 0; i < 14; i++) begin
            logic [31:0]      data;
            logic             d;
            logic [CNT_W-1:0] a;
            int s, lat, decs;
            logic [31:0] exp_sh;
            if (i < 4) begin
                data = t_data[i]; d = t_dir[i]; a = t_amt[i];
            end else begin
                data = $urandom; d = 1'($urandom); a = CNT_W'($urandom_range(0, 63));
            end
            s = clamp_amt(a);
            exp_sh = ref_shift(data, d, s);
            do_op(data, d, a, lat, decs);
            n_cmp++; if (lat !== s + 2)      begin n_bad++; $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, s + 2); end
            n_cmp++; if (decs !== s)         begin n_bad++; $display("FAIL op%0d_dec_cycles: got %0d expected %0d", i, decs, s); end
            n_cmp++; if (sh_val !== exp_sh)  begin n_bad++; $display("FAIL op%0d_shifter: got %h expected %h", i, sh_val, exp_sh); end
            n_cmp++; if (cnt_val !== '0)     begin n_bad++; $display("FAIL op%0d_counter: got %0d expected 0", i, cnt_val); end
            n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL op%0d_err: got %b expected 0", i, err); end
            n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL op%0d_busy_in_done: got %b expected 1", i, busy); end
            $display("op%0d: data=%h dir=%b amt=%0d lat=%0d decs=%0d result=%h", i, data, d, a, lat, decs, sh_val);
            ack_done();
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL op%0d_ack: got busy=%b done=%b expected 0 0", i, busy, done); end
        end
    endtask

    task automatic test_abort();
        logic done_seen = 1'b0;
        int lat, decs;
        logic [31:0] data2;
        @(negedge clk);
        sh_din = 32'hDEAD_BEEF; dir = 1'b0; amt = 6'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt_m !== M_LOAD || sh_m !== M_LOAD) begin n_bad++; $display("FAIL load_modes: got %b/%b expected 11/11", cnt_m, sh_m); end
        n_cmp++; if (cnt_d !== 6'd10) begin n_bad++; $display("FAIL load_cnt_d: got %0d expected 10", cnt_d); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sh_m !== M_UP_SHL) begin n_bad++; $display("FAIL shift_left_mode: got %b expected 01", sh_m); end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
            if (k == 0) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
                n_cmp++; if (cnt_m !== M_HOLD || sh_m !== M_HOLD) begin n_bad++; $display("FAIL abort_modes: got %b/%b expected 00/00", cnt_m, sh_m); end
            end
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL abort_done_pulse: got %b expected 0", done_seen); end
        n_cmp++; if (cnt_val !== 6'd7)   begin n_bad++; $display("FAIL abort_counter: got %0d expected 7", cnt_val); end
        $display("abort: counter=%0d busy=%b done_seen=%b", cnt_val, busy, done_seen);
        data2 = $urandom;
        do_op(data2, 1'b0, 6'd3, lat, decs);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL after_abort_latency: got %0d expected 5", lat); end
        n_cmp++; if (sh_val !== (data2 << 3)) begin n_bad++; $display("FAIL after_abort_shifter: got %h expected %h", sh_val, data2 << 3); end
        ack_done();
    endtask

    task automatic test_stuck();
        int lat, decs;
        stuck = 1'b1;
        do_op(32'hFFFF_FFFF, 1'b1, 6'd10, lat, decs);
        n_cmp++; if (lat !== MAX_SHIFT + 2) begin n_bad++; $display("FAIL stuck_latency: got %0d expected %0d", lat, MAX_SHIFT + 2); end
        n_cmp++; if (decs !== MAX_SHIFT)    begin n_bad++; $display("FAIL stuck_dec_cycles: got %0d expected %0d", decs, MAX_SHIFT); end
        n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL stuck_done_err: got %b/%b expected 1/1", done, err); end
        n_cmp++; if (cnt_m !== M_HOLD || sh_m !== M_HOLD) begin n_bad++; $display("FAIL stuck_modes: got %b/%b expected 00/00", cnt_m, sh_m); end
        $display("stuck: lat=%0d decs=%0d err=%b", lat, decs, err);
        ack_done();
        stuck = 1'b0;
        @(negedge clk);
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stuck_ack: got err=%b busy=%b expected 0 0", err, busy); end
    endtask

    task automatic test_clr_mid();
        logic done_seen = 1'b0;
        @(negedge clk);
        sh_din = $urandom; dir = 1'b1; amt = 6'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr = 1'b1; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL clr_flags: got busy/done/err=%b expected 000", {busy, done, err}); end
        n_cmp++; if ({cnt_m, sh_m} !== 4'b0000)    begin n_bad++; $display("FAIL clr_modes: got %b expected 0000", {cnt_m, sh_m}); end
        n_cmp++; if (cnt_d !== '0)                 begin n_bad++; $display("FAIL clr_cnt_d: got %0d expected 0", cnt_d); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL clr_stays_idle: got activity=%b expected 0", done_seen); end
        $display("clr_mid: busy=%b done=%b err=%b", busy, done, err);
    endtask

    task automatic test_back_to_back();
        int lat = 0, decs = 0, lat2, decs2;
        logic [31:0] data, data2;
        data = $urandom;
        @(negedge clk);
        sh_din = data; dir = 1'b0; amt = 6'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (cnt_m === M_DN_SHR) decs++;
            if (lat == 3) begin
                start = 1'b1; amt = 6'd3; dir = 1'b1; done_ack = 1'b1;
            end else begin
                start = 1'b0; done_ack = 1'b0;
            end
            @(posedge clk);
            lat++;
        end
        start = 1'b0; done_ack = 1'b0;
        n_cmp++; if (lat !== 10)           begin n_bad++; $display("FAIL busy_start_latency: got %0d expected 10", lat); end
        n_cmp++; if (decs !== 8)           begin n_bad++; $display("FAIL busy_start_decs: got %0d expected 8", decs); end
        n_cmp++; if (sh_val !== data << 8) begin n_bad++; $display("FAIL busy_start_shifter: got %h expected %h", sh_val, data << 8); end
        @(negedge clk);
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_in_done: got done=%b busy=%b expected 1 1", done, busy); end
        ack_done();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_not_queued: got busy=%b expected 0", busy); end
        data2 = $urandom;
        do_op(data2, 1'b1, 6'd5, lat2, decs2);
        n_cmp++; if (lat2 !== 7)             begin n_bad++; $display("FAIL b2b_latency: got %0d expected 7", lat2); end
        n_cmp++; if (sh_val !== data2 >> 5)  begin n_bad++; $display("FAIL b2b_shifter: got %h expected %h", sh_val, data2 >> 5); end
        $display("back_to_back: lat1=%0d lat2=%0d result=%h", lat, lat2, sh_val);
        ack_done();
    endtask

    initial begin
        test_reset();
        test_shift_ops();
        test_abort();
        test_stuck();
        test_clr_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit reached");
    end

endmodule
